// File: rtl/jardim_pkg.sv
// rtl/jardim_pkg.sv - shared constants for the irrigation controller key front-end
package jardim_pkg;

  localparam int CLK_HZ      = 50000000;
  localparam int DEBOUNCE_MS = 20;

  localparam int KEY_DAWN = 2;
  localparam int KEY_DUSK = 1;
  localparam int KEY_CTRL = 0;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - raw key inputs and conditioned level/pulse outputs
interface key_conditioner_if #(
  parameter int NUM_KEYS = 3
);

  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_rel;

  modport master (
    output KEY,
    input  key_level,
    input  key_press,
    input  key_rel
  );

  modport slave (
    input  KEY,
    output key_level,
    output key_press,
    output key_rel
  );

endinterface

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: 2-FF sync, debounce counter, press/release pulses
// Release pulse logic exists only when JARDIM_KEY_RELEASE_PULSE_EN is defined.
module key_debounce_ch
  import jardim_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic CLOCK_50,
  input  logic RESET_N,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_rel
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1 <= KEY_RELEASED;
      s2 <= KEY_RELEASED;
    end else begin
      s1 <= key_raw;
      s2 <= s1;
    end
  end

  // Any sample agreeing with the accepted level restarts the count.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt       <= '0;
      key_level <= KEY_RELEASED;
      key_press <= 1'b0;
    end else begin
      key_press <= 1'b0;
      if (s2 == key_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        key_level <= s2;
        key_press <= (s2 == KEY_PRESSED);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef JARDIM_KEY_RELEASE_PULSE_EN
  logic accept;
  assign accept = (s2 != key_level) && (cnt == CNT_LAST);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_rel <= 1'b0;
    end else begin
      key_rel <= accept && (s2 == KEY_RELEASED);
    end
  end
`else
  assign key_rel = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - conditions the dawn/dusk/control push-buttons for the irrigation FSM
// Optional release pulses: define JARDIM_KEY_RELEASE_PULSE_EN.
module key_conditioner
  import jardim_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS)
) (
  input logic               CLOCK_50,
  input logic               RESET_N,
  key_conditioner_if.slave  kif
);

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rel;

  // Channels are fully independent; simultaneous presses are not arbitrated here.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .CLOCK_50  (CLOCK_50),
      .RESET_N   (RESET_N),
      .key_raw   (kif.KEY[i]),
      .key_level (level[i]),
      .key_press (press[i]),
      .key_rel   (rel[i])
    );
  end

  assign kif.key_level = level;
  assign kif.key_press = press;
  assign kif.key_rel   = rel;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - self-checking bench for key_conditioner (DEBOUNCE_CYCLES = 8)
module tb_key_conditioner;

  localparam int NK = 3;
  localparam int D  = 8;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;

  key_conditioner_if #(.NUM_KEYS(NK)) kif ();

  key_conditioner #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .kif      (kif)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last D synchronized samples all disagree with it.
  logic [NK-1:0] m_s1    = '1;
  logic [NK-1:0] m_s2    = '1;
  logic [NK-1:0] m_level = '1;
  logic [NK-1:0] m_press = '0;
  logic [NK-1:0] m_rel   = '0;
  logic [NK-1:0] hist[$];

  function automatic bit all_differ(input int ch);
    if (hist.size() < D) return 1'b0;
    foreach (hist[j]) if (hist[j][ch] == m_level[ch]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      m_s1 = '1; m_s2 = '1; m_level = '1; m_press = '0; m_rel = '0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < NK; i++) begin
        if (all_differ(i)) begin
          if (m_level[i]) m_press[i] = 1'b1;
          else            m_rel[i]   = 1'b1;
          m_level[i] = ~m_level[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = kif.KEY;
    end
  end

  always @(posedge CLOCK_50) begin
    if (chk_en) begin
      #1;
      chk("model_level", 32'(kif.key_level), 32'(m_level));
      chk("model_press", 32'(kif.key_press), 32'(m_press));
`ifdef JARDIM_KEY_RELEASE_PULSE_EN
      chk("model_rel", 32'(kif.key_rel), 32'(m_rel));
`else
      chk("model_rel", 32'(kif.key_rel), 32'(0));
`endif
    end
  end

  task automatic measure(input string name, input bit rel, input logic [NK-1:0] exp_val);
    int cyc;
    logic [NK-1:0] v;
    cyc = 0;
    v   = '0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge CLOCK_50); #1;
      v = rel ? kif.key_rel : kif.key_press;
      if (v != '0) begin
        cyc = c;
        break;
      end
    end
    chk({name, "_cycle"}, 32'(cyc), 32'(D + 2));
    chk({name, "_value"}, 32'(v), 32'(exp_val));
    @(posedge CLOCK_50); #1;
    v = rel ? kif.key_rel : kif.key_press;
    chk({name, "_single"}, 32'(v), 32'(0));
  endtask

  task automatic hold(input logic [NK-1:0] k, input int n);
    @(negedge CLOCK_50);
    kif.KEY = k;
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  typedef struct {
    logic [NK-1:0] key;
    int            cycles;
    logic [NK-1:0] exp_level;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [NK-1:0] acc_press;
    logic [NK-1:0] acc_rel;
    logic          lvl2;

    vecs[0] = '{3'b000, 12, 3'b000};
    vecs[1] = '{3'b111,  9, 3'b000};
    vecs[2] = '{3'b111,  3, 3'b111};
    vecs[3] = '{3'b101, 10, 3'b101};
    vecs[4] = '{3'b011,  4, 3'b101};
    vecs[5] = '{3'b011,  8, 3'b011};
    vecs[6] = '{3'b001,  5, 3'b011};
    vecs[7] = '{3'b011, 12, 3'b011};
    vecs[8] = '{3'b100, 12, 3'b100};
    vecs[9] = '{3'b111, 12, 3'b111};

    kif.KEY = 3'b000;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset_level", 32'(kif.key_level), 32'(3'b111));
    chk("reset_press", 32'(kif.key_press), 32'(0));
    chk("reset_rel",   32'(kif.key_rel),   32'(0));
    chk_en = 1'b1;

    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    measure("held_through_reset", 1'b0, 3'b111);

    hold(3'b111, 12);
    chk("all_released", 32'(kif.key_level), 32'(3'b111));

    @(negedge CLOCK_50);
    kif.KEY = 3'b110;
    measure("clean_press", 1'b0, 3'b001);
    chk("clean_level", 32'(kif.key_level), 32'(3'b110));

    acc_press = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (i % 3 == 0) kif.KEY[1] = ~kif.KEY[1];
      @(posedge CLOCK_50); #1;
      acc_press |= kif.key_press;
    end
    chk("bounce_no_pulse", 32'(acc_press), 32'(0));
    @(negedge CLOCK_50);
    kif.KEY[1] = 1'b0;
    measure("bounce_final", 1'b0, 3'b010);

    hold(3'b111, 15);
    @(negedge CLOCK_50);
    kif.KEY = 3'b011;
    acc_press = '0;
    lvl2      = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (i == 7) begin
        @(negedge CLOCK_50);
        kif.KEY = 3'b111;
      end
      @(posedge CLOCK_50); #1;
      acc_press |= kif.key_press;
      lvl2      &= kif.key_level[2];
    end
    chk("glitch_no_pulse", 32'(acc_press), 32'(0));
    chk("glitch_level",    32'(lvl2),      32'(1));

    @(negedge CLOCK_50);
    kif.KEY = 3'b010;
    measure("simultaneous", 1'b0, 3'b101);

    @(negedge CLOCK_50);
    kif.KEY = 3'b111;
`ifdef JARDIM_KEY_RELEASE_PULSE_EN
    measure("release", 1'b1, 3'b101);
`else
    acc_rel = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLOCK_50); #1;
      acc_rel |= kif.key_rel;
    end
    chk("release_tied_low", 32'(acc_rel), 32'(0));
`endif

    for (int v = 0; v < 10; v++) begin
      hold(vecs[v].key, vecs[v].cycles);
      chk($sformatf("vec%0d_level", v), 32'(kif.key_level), 32'(vecs[v].exp_level));
    end

    for (int n = 0; n < 150; n++) begin
      if (n == 75) begin
        @(negedge CLOCK_50);
        kif.KEY = 3'b000;
        repeat (5) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET_N = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
      end
      hold(NK'($urandom), int'($urandom_range(1, 14)));
    end
    hold(3'b111, 12);

    chk_en = 1'b0;
    @(posedge CLOCK_50); #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
